// File: rtl/cpu_prog_ctrl_if.sv
// Board-side and CPU-side signals of the program controller, bundled as one interface.
// slave = the controller, master = whoever drives loader, switches, buttons and CPU address.
interface cpu_prog_ctrl_if;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       run;
    logic       step_btn;
    logic [3:0] cpu_adr;
    logic [7:0] cpu_dout;
    logic       cpu_reset;
    logic       cpu_tick;
    logic       halted;
    logic [2:0] state;

    modport slave (
        input  ld_start, ld_valid, ld_data, run, step_btn, cpu_adr,
        output ld_ready, cpu_dout, cpu_reset, cpu_tick, halted, state
    );

    modport master (
        output ld_start, ld_valid, ld_data, run, step_btn, cpu_adr,
        input  ld_ready, cpu_dout, cpu_reset, cpu_tick, halted, state
    );
endinterface

// File: rtl/cpu_prog_ctrl.sv
// Program memory owner and sequencer for the 4-bit CPU: loads 16 bytes, releases the CPU, issues ticks, halts on JMP-to-self.
// Latency: all control outputs registered (1 cycle); program read is combinational. Backpressure: ld_ready only in LOAD.
module cpu_prog_ctrl #(
    parameter int DIV_MAX = 13_500_000,
    parameter int DIV_W   = $clog2(DIV_MAX)
) (
    input  logic          clk,
    input  logic          reset,
    cpu_prog_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_EXEC    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

    logic [7:0]       r_mem [16];
    state_t           r_state,     w_state_nxt;
    logic [3:0]       r_wr_ptr,    w_wr_ptr_nxt;
    logic [DIV_W-1:0] r_div,       w_div_nxt;
    logic             r_tick,      w_tick_nxt;
    logic             r_cpu_reset, w_cpu_reset_nxt;
    logic             r_ld_ready,  w_ld_ready_nxt;
    logic             r_halted,    w_halted_nxt;
    logic             r_run_q;

    logic [7:0]       w_instr;
    logic             w_wr_en;
    logic             w_self_jmp;
    logic             w_run_chg;

    assign w_instr    = r_mem[bus.cpu_adr];
    assign w_wr_en    = (r_state == S_LOAD) && bus.ld_valid && r_ld_ready;
    // Only unconditional JMP (opcode 9) back onto its own address stops the CPU.
    assign w_self_jmp = (w_instr[7:4] == 4'b1001) && (w_instr[3:0] == bus.cpu_adr);
    assign w_run_chg  = bus.run ^ r_run_q;

    // Program store has no reset so a reset mid-load keeps earlier contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= 4'd0;
            r_div       <= '0;
            r_tick      <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_ld_ready  <= 1'b0;
            r_halted    <= 1'b0;
            r_run_q     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_div       <= w_div_nxt;
            r_tick      <= w_tick_nxt;
            r_cpu_reset <= w_cpu_reset_nxt;
            r_ld_ready  <= w_ld_ready_nxt;
            r_halted    <= w_halted_nxt;
            r_run_q     <= bus.run;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_div_nxt       = r_div;
        w_tick_nxt      = 1'b0;
        w_cpu_reset_nxt = 1'b0;
        w_ld_ready_nxt  = 1'b0;
        w_halted_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.ld_start) begin
                    w_state_nxt    = S_LOAD;
                    w_wr_ptr_nxt   = 4'd0;
                    w_ld_ready_nxt = 1'b1;
                end
            end

            S_LOAD: begin
                w_ld_ready_nxt = 1'b1;
                if (w_wr_en) begin
                    w_wr_ptr_nxt = r_wr_ptr + 4'd1;
                    if (r_wr_ptr == 4'hF) begin
                        w_state_nxt    = S_RELEASE;
                        w_ld_ready_nxt = 1'b0;
                    end
                end
            end

            S_RELEASE: begin
                w_div_nxt       = '0;
                w_cpu_reset_nxt = 1'b1;
                w_state_nxt     = S_EXEC;
            end

            S_EXEC: begin
                if (bus.ld_start) begin
                    w_state_nxt    = S_LOAD;
                    w_wr_ptr_nxt   = 4'd0;
                    w_ld_ready_nxt = 1'b1;
                end else begin
                    w_cpu_reset_nxt = 1'b1;
                    if (!bus.run || w_run_chg) begin
                        w_div_nxt = '0;
                    end else begin
                        w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
                    end
                    // Halt detection wins over any tick due this cycle.
                    if (w_self_jmp) begin
                        w_state_nxt  = S_HALT;
                        w_halted_nxt = 1'b1;
                    end else if (!bus.run) begin
                        w_tick_nxt = bus.step_btn;
                    end else if (!w_run_chg) begin
                        w_tick_nxt = (r_div == DIV_LAST);
                    end
                end
            end

            S_HALT: begin
                if (bus.ld_start) begin
                    w_state_nxt    = S_LOAD;
                    w_wr_ptr_nxt   = 4'd0;
                    w_ld_ready_nxt = 1'b1;
                end else begin
                    w_halted_nxt    = 1'b1;
                    w_cpu_reset_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.cpu_dout  = w_instr;
    assign bus.ld_ready  = r_ld_ready;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.cpu_tick  = r_tick;
    assign bus.halted    = r_halted;
    assign bus.state     = r_state;

endmodule
